// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: execute redirect/BTB training, instruction-memory port
// and the decode-side valid/ready handshake.
interface fetch_unit_if #(
  parameter int unsigned ADDR_WIDTH = 10
);
  logic                  redirect_i;
  logic [31:0]           redirect_pc_i;
  logic                  btb_upd_i;
  logic [31:0]           btb_upd_pc_i;
  logic [31:0]           btb_upd_target_i;
  logic                  btb_upd_taken_i;
  logic                  imem_req_o;
  logic [ADDR_WIDTH-1:0] imem_addr_o;
  logic [31:0]           imem_rdata_i;
  logic                  instr_valid_o;
  logic                  instr_ready_i;
  logic [31:0]           instr_o;
  logic [31:0]           pc_o;
  logic                  pred_taken_o;
  logic [31:0]           pred_target_o;

  modport master (
    input  redirect_i, redirect_pc_i, btb_upd_i, btb_upd_pc_i, btb_upd_target_i,
           btb_upd_taken_i, imem_rdata_i, instr_ready_i,
    output imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o, pred_taken_o,
           pred_target_o
  );

  modport slave (
    output redirect_i, redirect_pc_i, btb_upd_i, btb_upd_pc_i, btb_upd_target_i,
           btb_upd_taken_i, imem_rdata_i, instr_ready_i,
    input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o, pred_taken_o,
           pred_target_o
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC with direct-mapped BTB prediction, one imem
// read per cycle, fetch queue toward decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h100,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned FQ_DEPTH    = 4,
  parameter int unsigned BTB_ENTRIES = 16
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);
  localparam int unsigned IDX = $clog2(BTB_ENTRIES);
  localparam int unsigned PW  = $clog2(FQ_DEPTH);
  localparam int unsigned TW  = 30 - IDX;

  logic [31:0]      r_fetch_pc;
  logic             r_if_valid;
  logic [31:0]      r_if_pc;
  logic             r_if_taken;
  logic [31:0]      r_if_target;

  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW:0]      r_count;
  logic [31:0]      r_fq_instr  [FQ_DEPTH];
  logic [31:0]      r_fq_pc     [FQ_DEPTH];
  logic [31:0]      r_fq_target [FQ_DEPTH];
  logic             r_fq_taken  [FQ_DEPTH];

  logic [BTB_ENTRIES-1:0] r_btb_valid;
  logic [TW-1:0]          r_btb_tag    [BTB_ENTRIES];
  logic [31:0]            r_btb_target [BTB_ENTRIES];

  logic [IDX-1:0]   w_lk_idx;
  logic [IDX-1:0]   w_up_idx;
  logic             w_hit;
  logic [31:0]      w_next_pc;
  logic [PW+1:0]    w_occ;
  logic             w_issue;
  logic             w_push;
  logic             w_pop;
  logic             w_unused;

  assign w_lk_idx  = r_fetch_pc[IDX+1:2];
  assign w_up_idx  = bus.btb_upd_pc_i[IDX+1:2];
  assign w_hit     = r_btb_valid[w_lk_idx] && (r_btb_tag[w_lk_idx] == r_fetch_pc[31:IDX+2]);
  assign w_next_pc = w_hit ? r_btb_target[w_lk_idx] : r_fetch_pc + 32'd4;
  assign w_unused  = ^bus.btb_upd_pc_i[1:0];

  // Reserve a queue slot for the word still in flight so a push never overflows.
  assign w_occ   = {1'b0, r_count} + {{(PW+1){1'b0}}, r_if_valid};
  assign w_issue = !bus.redirect_i && (w_occ < (PW+2)'(FQ_DEPTH));
  assign w_push  = r_if_valid;
  assign w_pop   = (r_count != '0) && bus.instr_ready_i;

  assign bus.imem_req_o    = w_issue && rst;
  assign bus.imem_addr_o   = r_fetch_pc[ADDR_WIDTH+1:2];
  assign bus.instr_valid_o = (r_count != '0);
  assign bus.instr_o       = r_fq_instr[r_rd_ptr];
  assign bus.pc_o          = r_fq_pc[r_rd_ptr];
  assign bus.pred_taken_o  = r_fq_taken[r_rd_ptr];
  assign bus.pred_target_o = r_fq_target[r_rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc  <= RESET_PC;
      r_if_valid  <= 1'b0;
      r_if_pc     <= '0;
      r_if_taken  <= 1'b0;
      r_if_target <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
    end else if (bus.redirect_i) begin
      r_fetch_pc <= bus.redirect_pc_i;
      r_if_valid <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_if_valid <= w_issue;
      if (w_issue) begin
        r_fetch_pc  <= w_next_pc;
        r_if_pc     <= r_fetch_pc;
        r_if_taken  <= w_hit;
        r_if_target <= w_next_pc;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !bus.redirect_i) begin
      r_fq_instr[r_wr_ptr]  <= bus.imem_rdata_i;
      r_fq_pc[r_wr_ptr]     <= r_if_pc;
      r_fq_taken[r_wr_ptr]  <= r_if_taken;
      r_fq_target[r_wr_ptr] <= r_if_target;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_btb_valid <= '0;
    end else if (bus.btb_upd_i) begin
      r_btb_valid[w_up_idx] <= bus.btb_upd_taken_i;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.btb_upd_i && bus.btb_upd_taken_i) begin
      r_btb_tag[w_up_idx]    <= bus.btb_upd_pc_i[31:IDX+2];
      r_btb_target[w_up_idx] <= bus.btb_upd_target_i;
    end
  end
endmodule
